// File: rtl/branch_check_multi.sv
// Per-thread branch detector for the barrel pipeline: prioritised entries with
// flag or loop-counter conditions, 3-cycle latency, re-issue recirculation.
module branch_check_multi #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0,
  parameter int ENTRY_COUNT       = 2,
  parameter int ENTRY_ADDR_WIDTH  = 1,
  parameter int FLAGS_WORD_WIDTH  = 8,
  parameter int FLAGS_ADDR_WIDTH  = 3,
  parameter int COUNTER_WIDTH     = 8,
  localparam int COND_WIDTH       = FLAGS_ADDR_WIDTH + 2,
  localparam int WRITE_WIDTH      = (PC_WIDTH >= COUNTER_WIDTH)
                                    ? ((PC_WIDTH >= COND_WIDTH) ? PC_WIDTH : COND_WIDTH)
                                    : ((COUNTER_WIDTH >= COND_WIDTH) ? COUNTER_WIDTH : COND_WIDTH),
  localparam int ADDR_WIDTH       = THREAD_ADDR_WIDTH + ENTRY_ADDR_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PC_WIDTH-1:0]         PC,
  input  logic [FLAGS_WORD_WIDTH-1:0] flags,
  input  logic                        IO_ready_previous,
  input  logic                        wren_origin,
  input  logic                        wren_destination,
  input  logic                        wren_condition,
  input  logic                        wren_reload,
  input  logic [ADDR_WIDTH-1:0]       write_addr,
  input  logic [WRITE_WIDTH-1:0]      write_data,
  output logic [PC_WIDTH-1:0]         branch_destination,
  output logic                        jump
);

  localparam int SLOTS = THREAD_COUNT * ENTRY_COUNT;

  function automatic logic condition_met(
    input logic [COND_WIDTH-1:0]       cond_word,
    input logic [COUNTER_WIDTH-1:0]    count,
    input logic [FLAGS_WORD_WIDTH-1:0] flag_word
  );
    if (cond_word[FLAGS_ADDR_WIDTH+1])
      return count != '0;
    return flag_word[cond_word[FLAGS_ADDR_WIDTH-1:0]] ^ cond_word[FLAGS_ADDR_WIDTH];
  endfunction

  logic [THREAD_ADDR_WIDTH-1:0] thr;

  logic [PC_WIDTH-1:0]      origin_ram      [SLOTS];
  logic [PC_WIDTH-1:0]      destination_ram [SLOTS];
  logic [COND_WIDTH-1:0]    condition_ram   [SLOTS];
  logic [COUNTER_WIDTH-1:0] reload_ram      [SLOTS];
  logic [SLOTS-1:0]         valid;
  logic [COUNTER_WIDTH-1:0] counter         [SLOTS];

  logic                         vld_p0, io_ready_p0;
  logic [PC_WIDTH-1:0]          pc_p0;
  logic [FLAGS_WORD_WIDTH-1:0]  flags_p0;
  logic [THREAD_ADDR_WIDTH-1:0] thread_p0;
  logic [ENTRY_COUNT-1:0]       valid_p0;
  logic [PC_WIDTH-1:0]          origin_p0      [ENTRY_COUNT];
  logic [PC_WIDTH-1:0]          destination_p0 [ENTRY_COUNT];
  logic [COND_WIDTH-1:0]        condition_p0   [ENTRY_COUNT];
  logic [COUNTER_WIDTH-1:0]     counter_p0     [ENTRY_COUNT];

  logic                         vld_p1, io_ready_p1;
  logic [THREAD_ADDR_WIDTH-1:0] thread_p1;
  logic [ENTRY_COUNT-1:0]       hit_p1, cond_p1, mode_p1;
  logic [PC_WIDTH-1:0]          destination_p1 [ENTRY_COUNT];
  logic [COUNTER_WIDTH-1:0]     counter_p1     [ENTRY_COUNT];

  logic                    taken;
  logic [PC_WIDTH-1:0]     target;
  logic [THREAD_COUNT-1:0] recirc_jump;
  logic [PC_WIDTH-1:0]     recirc_dest [THREAD_COUNT];

  always_ff @(posedge clock) begin
    if (reset)
      thr <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
    else
      thr <= thr + 1'b1;
  end

  // Entry RAMs are not reset; a written origin is what makes an entry live.
  always_ff @(posedge clock) begin
    if (wren_origin)      origin_ram[write_addr]      <= write_data[PC_WIDTH-1:0];
    if (wren_destination) destination_ram[write_addr] <= write_data[PC_WIDTH-1:0];
    if (wren_condition)   condition_ram[write_addr]   <= write_data[COND_WIDTH-1:0];
    if (wren_reload)      reload_ram[write_addr]      <= write_data[COUNTER_WIDTH-1:0];
  end

  // S0: capture inputs and read all entries of the current thread
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      io_ready_p0 <= 1'b0;
      pc_p0       <= '0;
      flags_p0    <= '0;
      thread_p0   <= '0;
      valid_p0    <= '0;
      for (int e = 0; e < ENTRY_COUNT; e++) begin
        origin_p0[e]      <= '0;
        destination_p0[e] <= '0;
        condition_p0[e]   <= '0;
        counter_p0[e]     <= '0;
      end
    end else begin
      vld_p0      <= 1'b1;
      io_ready_p0 <= IO_ready_previous;
      pc_p0       <= PC;
      flags_p0    <= flags;
      thread_p0   <= thr;
      for (int e = 0; e < ENTRY_COUNT; e++) begin
        valid_p0[e]       <= valid[{thr, ENTRY_ADDR_WIDTH'(e)}];
        origin_p0[e]      <= origin_ram[{thr, ENTRY_ADDR_WIDTH'(e)}];
        destination_p0[e] <= destination_ram[{thr, ENTRY_ADDR_WIDTH'(e)}];
        condition_p0[e]   <= condition_ram[{thr, ENTRY_ADDR_WIDTH'(e)}];
        counter_p0[e]     <= counter[{thr, ENTRY_ADDR_WIDTH'(e)}];
      end
    end
  end

  // S1: per-entry hit and condition evaluation
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      io_ready_p1 <= 1'b0;
      thread_p1   <= '0;
      hit_p1      <= '0;
      cond_p1     <= '0;
      mode_p1     <= '0;
      for (int e = 0; e < ENTRY_COUNT; e++) begin
        destination_p1[e] <= '0;
        counter_p1[e]     <= '0;
      end
    end else begin
      vld_p1      <= vld_p0;
      io_ready_p1 <= io_ready_p0;
      thread_p1   <= thread_p0;
      for (int e = 0; e < ENTRY_COUNT; e++) begin
        hit_p1[e]         <= valid_p0[e] && (origin_p0[e] == pc_p0);
        cond_p1[e]        <= condition_met(condition_p0[e], counter_p0[e], flags_p0);
        mode_p1[e]        <= condition_p0[e][FLAGS_ADDR_WIDTH+1];
        destination_p1[e] <= destination_p0[e];
        counter_p1[e]     <= counter_p0[e];
      end
    end
  end

  // S2: priority select, lowest index wins; re-issue replays this thread's last decision
  always_comb begin
    taken  = 1'b0;
    target = '0;
    for (int e = ENTRY_COUNT - 1; e >= 0; e--) begin
      if (hit_p1[e] && cond_p1[e]) begin
        taken  = 1'b1;
        target = destination_p1[e];
      end
    end
    if (!io_ready_p1) begin
      taken  = recirc_jump[THREAD_COUNT-1];
      target = recirc_dest[THREAD_COUNT-1];
    end
    if (!vld_p1) begin
      taken  = 1'b0;
      target = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jump               <= 1'b0;
      branch_destination <= '0;
      recirc_jump        <= '0;
      for (int t = 0; t < THREAD_COUNT; t++)
        recirc_dest[t] <= '0;
    end else begin
      jump               <= taken;
      branch_destination <= target;
      recirc_jump        <= {recirc_jump[THREAD_COUNT-2:0], taken};
      recirc_dest[0]     <= target;
      for (int t = 1; t < THREAD_COUNT; t++)
        recirc_dest[t] <= recirc_dest[t-1];
    end
  end

  // Live loop counters: S2 update first, so a same-cycle ALU load overrides it.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      for (int s = 0; s < SLOTS; s++)
        counter[s] <= '0;
    end else begin
      if (vld_p1 && io_ready_p1) begin
        for (int e = 0; e < ENTRY_COUNT; e++) begin
          if (hit_p1[e] && mode_p1[e])
            counter[{thread_p1, ENTRY_ADDR_WIDTH'(e)}] <= cond_p1[e]
              ? counter_p1[e] - 1'b1
              : reload_ram[{thread_p1, ENTRY_ADDR_WIDTH'(e)}];
        end
      end
      if (wren_reload)
        counter[write_addr] <= write_data[COUNTER_WIDTH-1:0];
      if (wren_origin)
        valid[write_addr] <= 1'b1;
    end
  end

endmodule

// File: doc/branch_check_multi.md
Name: branch_check_multi

Overview:
- Next-generation per-thread branch detector for the barrel-threaded pipeline.
- Holds ENTRY_COUNT branch entries per thread. Each entry has an origin, a destination and a condition: either a selected and optionally inverted result flag, or a hardware loop counter.
- Emits a zero-or-destination / jump pair for OR-reduction ahead of the Controller.
- Adds over the previous generation: synchronous reset with entry valid bits, multiple prioritised entries, counter mode, and re-issue recirculation of destination as well as jump.

Parameters:
- PC_WIDTH, 10, program counter width.
- THREAD_COUNT, 8, threads in the barrel; power of two, at least 4.
- THREAD_ADDR_WIDTH, 3, log2(THREAD_COUNT).
- INITIAL_THREAD, 0, thread number the internal thread counter holds out of reset.
- ENTRY_COUNT, 2, branch entries per thread; power of two.
- ENTRY_ADDR_WIDTH, 1, log2(ENTRY_COUNT).
- FLAGS_WORD_WIDTH, 8, number of result flags.
- FLAGS_ADDR_WIDTH, 3, log2(FLAGS_WORD_WIDTH).
- COUNTER_WIDTH, 8, loop counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- PC  in  PC_WIDTH  PC of the current thread instruction.
- flags  in  FLAGS_WORD_WIDTH  result flags of that thread's previous instruction.
- IO_ready_previous  in  1  low means the instruction is a re-issue after an I/O stall.
- wren_origin  in  1  write origin entry; also sets the entry valid bit.
- wren_destination  in  1  write destination entry.
- wren_condition  in  1  write condition entry.
- wren_reload  in  1  write counter reload value; also loads the live counter.
- write_addr  in  THREAD_ADDR_WIDTH+ENTRY_ADDR_WIDTH  entry address = {thread, entry}.
- write_data  in  max(PC_WIDTH,COUNTER_WIDTH,FLAGS_ADDR_WIDTH+2)  write data, LSB-aligned.
- branch_destination  out  PC_WIDTH  taken destination, else 0.
- jump  out  1  branch taken.

Behaviour:
- Reset:
  - Thread counter = INITIAL_THREAD.
  - All valid bits, live counters, pipeline registers and recirculation line = 0.
  - jump = 0, branch_destination = 0 from the cycle after reset is sampled.
  - Origin, destination, condition and reload RAMs are not reset.
- Thread counter: increments every cycle, modulo THREAD_COUNT. Inputs at cycle t belong to thread thr(t).
- Condition word layout: [FLAGS_ADDR_WIDTH-1:0] flag select; bit FLAGS_ADDR_WIDTH = invert; bit FLAGS_ADDR_WIDTH+1 = counter mode.
- Pipeline, fixed latency 3: inputs at cycle t produce outputs valid in cycle t+3.
  - S0 (t): register PC, flags and IO_ready_previous; synchronous RAM read at thr(t).
  - S1 (t+1): per entry, hit = valid & (origin == PC); cond = counter mode ? (live counter != 0) : (flags[sel] ^ invert). Register the results.
  - S2 (t+2): the lowest-index entry with hit & cond wins, producing the taken destination or 0 and jump. Register the outputs.
- Re-issue: if the registered IO_ready_previous is 0, S2 drives the outputs from the recirculation line instead. That line is a THREAD_COUNT-deep delay of {jump, branch_destination}, i.e. the same thread's previous decision.
- Counter mode, applied at S2 only when IO_ready_previous = 1 and the entry hit:
  - counter != 0: taken, counter decrements by 1.
  - counter == 0: not taken, counter reloads from the reload RAM.
  - Non-winning hit entries in counter mode update the same way.
- Simultaneous ALU write and S2 counter update to the same entry: the ALU write wins.
- A write to an entry in the cycle it is read returns the old data (read-during-write = old).
- Multiple hits: lowest index wins. Outputs are 0 when there is no hit, which is safe for external OR-reduction.
- Reset mid-stream: in-flight decisions are discarded; the first valid output is 3 cycles after reset deasserts and is 0 (all entries invalid).

Test Plan:
- After reset, no entry writes; drive PCs 0..1023 for 40 cycles -> jump = 0 and branch_destination = 0 throughout.
- Thread 2, entry 0: origin = 0x010, destination = 0x200, condition select = flag 3, not inverted; PC = 0x010 on thread 2 with flags = 0x08 at cycle t -> jump = 1, destination = 0x200 at t+3. With flags = 0x00 -> both 0.
- Thread 5, entries 0 and 1 both origin 0x040, destinations 0x100 and 0x180, both conditions true -> destination 0x100 (lowest index wins). Invalidate entry 0 by reset, rewrite entry 1 only -> 0x180.
- Counter mode, thread 1, reload = 3, origin 0x020; hit thread 1 at 0x020 on five successive rounds -> taken, taken, taken, not taken (reload), taken.
- Taken decision on thread 4; the next thread 4 slot has IO_ready_previous = 0 and flags = 0 -> jump = 1 with the same destination repeated, and the counter is not decremented.
- ALU wren_reload to {thread 1, entry 0} in the same cycle as S2 decrements it -> the counter equals the written value afterwards.
